// File: rtl/mem_dump_unit.sv
// ============================================================================
// mem_dump_unit: reads a word range from a sync-read memory and streams it
// out MSB-first as bytes. Optional CHECKSUM_EN appends a 4-byte XOR trailer.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_dump_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_FIN
`ifdef CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic [1:0]            r_idx;
    logic [31:0]           r_shift;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_out_byte;
    logic                  r_out_valid;
`ifdef CHECKSUM_EN
    logic [31:0]           r_csum;
`endif

    logic                  w_hs;
    logic [ADDR_WIDTH:0]   w_remain_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;

    assign w_hs         = r_out_valid & out_ready;
    assign w_remain_nxt = r_remain - 1'b1;
    assign w_addr_nxt   = r_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_mem_addr  <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_remain <= word_count;
                        r_idx    <= '0;
`ifdef CHECKSUM_EN
                        r_csum   <= '0;
`endif
                        if (word_count != '0) begin
                            r_state    <= S_READ;
                            r_busy     <= 1'b1;
                            r_rd_en    <= 1'b1;
                            r_mem_addr <= base_addr;
                        end else begin
`ifdef CHECKSUM_EN
                            // Empty range still emits an all-zero trailer.
                            r_state     <= S_CSUM;
                            r_busy      <= 1'b1;
                            r_shift     <= '0;
                            r_out_byte  <= '0;
                            r_out_valid <= 1'b1;
`else
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
                S_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_shift     <= mem_rdata;
`ifdef CHECKSUM_EN
                    r_csum      <= r_csum ^ mem_rdata;
`endif
                    r_out_byte  <= mem_rdata[31:24];
                    r_out_valid <= 1'b1;
                    r_idx       <= '0;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_remain    <= w_remain_nxt;
                            r_addr      <= w_addr_nxt;
                            if (w_remain_nxt != '0) begin
                                r_state    <= S_READ;
                                r_rd_en    <= 1'b1;
                                r_mem_addr <= w_addr_nxt;
                            end else begin
`ifdef CHECKSUM_EN
                                r_state     <= S_CSUM;
                                r_shift     <= r_csum;
                                r_out_byte  <= r_csum[31:24];
                                r_out_valid <= 1'b1;
`else
                                r_state <= S_FIN;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
`endif
                            end
                        end else begin
                            r_out_byte <= r_shift[23:16];
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_FIN;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_out_byte <= r_shift[23:16];
                        end
                    end
                end
`endif
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_mem_addr;
    assign out_byte  = r_out_byte;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_unit.sv
// ============================================================================
// tb_mem_dump_unit: scoreboard bench for mem_dump_unit (expected bytes and
// read addresses queued by stimulus, popped by a negedge monitor).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_dump_unit;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [7:0]    exp_bytes [$];
    logic [AW-1:0] exp_addr  [$];

    int n_tests = 0;
    int n_fail  = 0;
    int bytes_seen = 0;
    int ready_mode = 0;

    mem_dump_unit #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Sink ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1.
    initial begin
        int k;
        logic [3:0] pat;
        k = 0;
        pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else begin
                out_ready = pat[3 - (k % 4)];
                k++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: byte scoreboard, read-address scoreboard, hold-while-stalled.
    initial begin
        logic       prev_v;
        logic       prev_r;
        logic [7:0] prev_b;
        logic [7:0] eb;
        logic [AW-1:0] ea;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_b = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_v && !prev_r) begin
                    check("hold_valid", {31'd0, out_valid}, 32'd1);
                    check("hold_byte", {24'd0, out_byte}, {24'd0, prev_b});
                end
                if (out_valid && out_ready) begin
                    bytes_seen++;
                    if (exp_bytes.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL stream: unexpected byte %02h, required none", out_byte);
                    end else begin
                        eb = exp_bytes.pop_front();
                        check("stream_byte", {24'd0, out_byte}, {24'd0, eb});
                    end
                end
                if (mem_rd_en) begin
                    if (exp_addr.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL rd_addr: unexpected read at %0d, required none", mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        check("rd_addr", {22'd0, mem_addr}, {22'd0, ea});
                    end
                end
            end
            prev_v = out_valid & rst_n;
            prev_r = out_ready;
            prev_b = out_byte;
        end
    end

    task automatic push_range(input logic [AW-1:0] base, input logic [AW:0] cnt);
        logic [AW-1:0] a;
        logic [31:0]   w;
        logic [31:0]   acc;
        acc = '0;
        a = base;
        for (int i = 0; i < int'(cnt); i++) begin
            w = mem[a];
            acc = acc ^ w;
            exp_addr.push_back(a);
            exp_bytes.push_back(w[31:24]);
            exp_bytes.push_back(w[23:16]);
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
            a = a + 1'b1;
        end
`ifdef CHECKSUM_EN
        exp_bytes.push_back(acc[31:24]);
        exp_bytes.push_back(acc[23:16]);
        exp_bytes.push_back(acc[15:8]);
        exp_bytes.push_back(acc[7:0]);
`endif
    endtask

    task automatic do_dump(input logic [AW-1:0] base, input logic [AW:0] cnt,
                           input int mode, input bit busy_start);
        int  n;
        int  first;
        bit  seen;
        push_range(base, cnt);
        ready_mode = mode;
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = base; word_count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = '0; word_count = '0;
        if (busy_start) begin
            fork
                begin
                    repeat (3) @(posedge clk);
                    #1;
                    start = 1'b1; base_addr = 10'd5; word_count = 11'd3;
                    @(posedge clk);
                    #1;
                    start = 1'b0; base_addr = '0; word_count = '0;
                end
            join_none
        end
        n = 0; first = 0; seen = 1'b0;
        while (n < 3000 && !seen) begin
            @(negedge clk);
            n++;
            if (first == 0 && out_valid) first = n;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, required done", n);
            return;
        end
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (cnt != 0) check("first_valid_latency", first, 3);
`ifdef CHECKSUM_EN
        if (cnt == 0) check("done_cycle_zero", n, 5);
        if (cnt == 1 && mode == 0) check("done_cycle_one", n, 11);
`else
        if (cnt == 0) check("done_cycle_zero", n, 1);
        if (cnt == 1 && mode == 0) check("done_cycle_one", n, 7);
`endif
        @(negedge clk);
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("bytes_left", exp_bytes.size(), 0);
        check("reads_left", exp_addr.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'h5566_7788;
        mem[2] = 32'h0000_003A;
        mem[3] = 32'h99AA_BBCC;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outvalid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of the second word's SEND.
        push_range(10'd0, 11'd4);
        ready_mode = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd0; word_count = 11'd4;
        @(posedge clk); #1;
        start = 1'b0; word_count = '0;
        guard = 0;
        while (bytes_seen < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("reach_second_word", {31'd0, (bytes_seen >= 5)}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("arst_addr", {22'd0, mem_addr}, 32'd0);
        check("arst_byte", {24'd0, out_byte}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        exp_bytes.delete();
        exp_addr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        do_dump(10'd0, 11'd1, 0, 1'b0);

        // Single word at address 2.
        do_dump(10'd2, 11'd1, 0, 1'b0);

        // Backpressure on 0x0000010E.
        mem[0] = 32'h0000_010E;
        do_dump(10'd0, 11'd1, 1, 1'b0);

        // Wrap from the top of memory through address 0.
        mem[1023] = 32'hDEAD_BEEF;
        mem[0]    = 32'h0000_0004;
        do_dump(10'd1023, 11'd2, 0, 1'b0);

        // Empty range.
        do_dump(10'd7, 11'd0, 0, 1'b0);

        // Start pulse while busy must not disturb the latched range.
        mem[10] = 32'hCAFE_F00D;
        mem[11] = 32'h0BAD_1DEA;
        do_dump(10'd10, 11'd2, 1, 1'b1);

        // Checksum words 0x3A and 0x10E: trailer 00 00 01 34 when enabled.
        mem[2] = 32'h0000_003A;
        mem[3] = 32'h0000_010E;
        do_dump(10'd2, 11'd2, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_dump_unit.md
Name: mem_dump_unit

Overview:
Hardware readback engine for the single-cycle CPU's data memory. On a start pulse it reads a contiguous range of 32-bit words through a synchronous-read memory port. It streams each word out as bytes, MSB first, over a valid/ready byte interface. It lets the testbench, or a future host link, pull results such as the Fibonacci and Hanoi answers out of memory instead of peeking at internal registers.

Parameters:
ADDR_WIDTH, 10, word-address width of the memory port; the range wraps modulo 2^ADDR_WIDTH.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a dump; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address; latched on accepted start
word_count  input  ADDR_WIDTH+1  number of words to dump (0 .. 2^ADDR_WIDTH); latched on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the dump completes
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_WIDTH  memory word address
mem_rdata  input  32  read data, valid the cycle after mem_rd_en
out_byte  output  8  stream data
out_valid  output  1  stream valid
out_ready  input  1  stream ready from the sink

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_byte=0, out_valid=0. Internal address, remaining count, byte index, shift register and checksum are all 0. State is IDLE.
- Reset asserted mid-dump: immediate return to IDLE with the values above. No partial byte is completed.
- FSM states: IDLE, READ, WAIT, SEND, FIN.
- IDLE -> READ when start=1 and word_count!=0. Latch base_addr and word_count.
- IDLE -> FIN when start=1 and word_count==0. No memory access, no bytes sent.
- READ (1 cycle): mem_rd_en=1, mem_addr=current address. Next state WAIT.
- WAIT (1 cycle): capture mem_rdata into a 32-bit shift register at the end of the cycle. Next state SEND.
- SEND: out_valid=1 and out_byte=shift[31:24].
  - On out_valid && out_ready: shift left by 8 and increment the byte index.
  - After the 4th byte: decrement the remaining count and increment the address, wrapping modulo 2^ADDR_WIDTH.
  - Then go to READ if the remaining count != 0, otherwise FIN.
- Stream rules: while out_valid=1 and out_ready=0, out_byte holds stable. out_valid never drops without a handshake. out_valid=0 in all states other than SEND. Back-to-back bytes are allowed (one byte per cycle with out_ready held high). Per-word overhead is 2 idle cycles (READ, WAIT).
- FIN (1 cycle): done=1, busy=0 in the same cycle. Next state IDLE.
- busy is 1 in READ, WAIT and SEND.
- mem_rd_en is 0 outside READ. mem_addr holds its last value when mem_rd_en is not asserted.
- Latency: start sampled at edge E0. READ in cycle 1, WAIT in cycle 2, first out_valid in cycle 3.
- start while busy: ignored, with no effect on the latched range.
- word_count of 2^ADDR_WIDTH dumps the full memory once, starting at base_addr and wrapping through address 0.

Optional Feature:
CHECKSUM_EN:
- Defined: a 32-bit XOR accumulator is cleared on an accepted start and XORs in each captured word.
- After the last data byte, the FSM enters an extra state CSUM instead of FIN. CSUM sends the 4 accumulator bytes MSB first under the same handshake rules, then goes to FIN.
- For word_count==0, the 4 trailer bytes 00 00 00 00 are sent before FIN.
- Undefined: no accumulator, no CSUM state, and no trailer bytes.

Test Plan:
- Reset mid-stream: start with base=0, count=4; pull rst_n low while the 2nd word is in SEND -> all outputs 0 immediately; after release, busy=0 and a new dump with base=0, count=1 works normally.
- Single word: mem[2]=32'h0000_003A, start with base=2, count=1, out_ready=1 -> first out_valid 3 cycles after start; bytes 00 00 00 3A on 4 consecutive cycles; done pulses 1 cycle later; mem_rd_en asserted exactly once, with addr 2.
- Backpressure: mem[0]=32'h0000_010E, out_ready toggled 1,0,0,1,... -> out_byte is held while not ready; stream is 00 00 01 0E; no byte duplicated or dropped.
- Multi-word with wrap: ADDR_WIDTH=10, base=1023, count=2, mem[1023]=32'hDEADBEEF, mem[0]=32'h00000004 -> bytes DE AD BE EF 00 00 00 04; mem_addr sequence 1023 then 0.
- Zero count and busy start: start with count=0 -> done the next cycle, no out_valid, no mem_rd_en (with CHECKSUM_EN: 4 zero bytes, then done). A start pulse asserted during an active dump is ignored.
- CHECKSUM_EN: dump words 32'h0000003A and 32'h0000010E -> trailer 00 00 01 34 follows the 8 data bytes.
